// File: rtl/instr_fetch_pkg.sv
// Shared types and constants for the instruction fetch stage.
// Holds the fetch FSM encoding, the IF/ID register layout and the NOP word.
// Imported by instr_fetch; no logic of its own.
package instr_fetch_pkg;

  localparam int ILEN = 32;

  // NOP = addi x0, x0, 0
  localparam logic [ILEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    FETCH    = 2'd1,
    WAIT_DEC = 2'd2,
    FLUSH    = 2'd3
  } if_state_t;

  // One IF/ID slot: the instruction word and the address it came from.
  typedef struct packed {
    logic [ILEN-1:0] instr;
    logic [31:0]     pc;
  } ifid_t;

  // Fetch addresses are always word aligned.
  function automatic logic [31:0] align4(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/instr_fetch.sv
// Instruction fetch: issues word requests to imem and fills the IF/ID register.
// Latency: ack in cycle N -> instr/pc valid in cycle N+1; back-to-back acks give one instr per cycle.
// Backpressure: stall holds IF/ID; one word in flight is absorbed by a one-entry skid, then requests stop.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            rst,
  output logic            imem_req,
  output logic [31:0]     imem_addr,
  input  logic            imem_ack,
  input  logic [ILEN-1:0] imem_rdata,
  input  logic            stall,
  input  logic            redirect,
  input  logic [31:0]     redirect_pc,
  output logic            instr_valid,
  output logic [ILEN-1:0] instr,
  output logic [31:0]     pc,
  output logic [31:0]     pc_plus4
);

  if_state_t   state_q, state_d;
  logic [31:0] req_addr_q, req_addr_d;
  // Redirect target parked while FLUSH waits out the stale request.
  logic [31:0] tgt_q, tgt_d;
  ifid_t       ifid_q, ifid_d;
  logic        valid_q, valid_d;
  ifid_t       skid_q, skid_d;
  logic        skid_vld_q, skid_vld_d;

  assign imem_addr   = req_addr_q;
  assign instr_valid = valid_q;
  assign instr       = ifid_q.instr;
  assign pc          = ifid_q.pc;
  assign pc_plus4    = ifid_q.pc + 32'd4;

  // Register all fetch state; reset abandons any outstanding request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      req_addr_q <= RESET_PC;
      tgt_q      <= RESET_PC;
      ifid_q     <= '{instr: NOP, pc: RESET_PC};
      valid_q    <= 1'b0;
      skid_q     <= '{instr: NOP, pc: RESET_PC};
      skid_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      req_addr_q <= req_addr_d;
      tgt_q      <= tgt_d;
      ifid_q     <= ifid_d;
      valid_q    <= valid_d;
      skid_q     <= skid_d;
      skid_vld_q <= skid_vld_d;
    end
  end

  // Next-state and datapath updates; redirect outranks ack and stall everywhere.
  always_comb begin
    state_d    = state_q;
    req_addr_d = req_addr_q;
    tgt_d      = tgt_q;
    ifid_d     = ifid_q;
    valid_d    = valid_q;
    skid_d     = skid_q;
    skid_vld_d = skid_vld_q;
    imem_req   = 1'b0;

    case (state_q)
      IDLE: begin
        // Any ack seen here belongs to a request abandoned by reset.
        state_d = FETCH;
        if (redirect) begin
          req_addr_d = align4(redirect_pc);
        end
      end

      FETCH: begin
        imem_req = 1'b1;
        if (redirect) begin
          valid_d    = 1'b0;
          skid_vld_d = 1'b0;
          if (imem_ack) begin
            req_addr_d = align4(redirect_pc);
            state_d    = FETCH;
          end else begin
            // The old request is still on the bus; it must complete first.
            tgt_d   = align4(redirect_pc);
            state_d = FLUSH;
          end
        end else if (imem_ack) begin
          req_addr_d = req_addr_q + 32'd4;
          if (!valid_q || !stall) begin
            ifid_d.instr = imem_rdata;
            ifid_d.pc    = req_addr_q;
            valid_d      = 1'b1;
          end else begin
            skid_d.instr = imem_rdata;
            skid_d.pc    = req_addr_q;
            skid_vld_d   = 1'b1;
            state_d      = WAIT_DEC;
          end
        end else if (!stall) begin
          valid_d = 1'b0;
        end
      end

      WAIT_DEC: begin
        if (redirect) begin
          valid_d    = 1'b0;
          skid_vld_d = 1'b0;
          req_addr_d = align4(redirect_pc);
          state_d    = FETCH;
        end else if (!stall && skid_vld_q) begin
          ifid_d     = skid_q;
          skid_vld_d = 1'b0;
          state_d    = FETCH;
        end
      end

      FLUSH: begin
        imem_req = 1'b1;
        valid_d  = 1'b0;
        if (redirect) begin
          tgt_d = align4(redirect_pc);
        end
        if (imem_ack) begin
          // Returned word is stale and dropped; resume at the latest target.
          req_addr_d = redirect ? align4(redirect_pc) : tgt_q;
          state_d    = FETCH;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: random memory latency, stall and redirect traffic.
// The reference is the instruction stream decode should see: consecutive pcs, jumps on redirect.
// Memory contents are a fixed function of address so every delivered word can be recomputed.
module tb_instr_fetch;

  localparam logic [31:0] RESET_PC = 32'h0000_0100;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;
  localparam logic [31:0] JUNK     = 32'hDEAD_BEEF;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] pc;
  logic [31:0] pc_plus4;

  instr_fetch #(.RESET_PC(RESET_PC)) dut (
    .clk        (clk),
    .rst        (rst),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .stall      (stall),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .instr_valid(instr_valid),
    .instr      (instr),
    .pc         (pc),
    .pc_plus4   (pc_plus4)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  int n_consumed = 0;

  // 0: ack every cycle, 1: ack on the 2nd cycle of each request, 2: random
  int mode = 0;
  int lat_cnt = 0;

  // Expected pc of the next instruction decode accepts.
  logic [31:0] exp_next;

  // Observations from the previous cycle used for cycle-to-cycle rules.
  bit          have_prev;
  bit          p_hold, p_req, p_ack, p_stall, p_rdr, p_valid;
  logic [31:0] p_pc, p_instr, p_addr;

  bit          found;
  bit          did_reset;
  logic        r_st, r_rd;
  logic [31:0] r_pc;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5BD1_E995;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // One clock of stimulus, called at the falling edge.
  task automatic step(input logic st, input logic rd, input logic [31:0] rpc);
    logic a;
    if (have_prev) begin
      if (p_hold) begin
        check("hold_valid", instr_valid, 1'b1);
        check("hold_pc", pc, p_pc);
        check("hold_instr", instr, p_instr);
      end
      if (p_req && !p_ack) begin
        check("req_stable", imem_req, 1'b1);
        check("addr_stable", imem_addr, p_addr);
      end
      if (p_rdr) check("valid_after_redirect", instr_valid, 1'b0);
      else if (p_req && !p_ack && !p_stall) check("valid_gap", instr_valid, 1'b0);
      if (p_req && p_ack && p_valid && p_stall && !p_rdr) check("req_off_when_full", imem_req, 1'b0);
    end
    check("pc_plus4", pc_plus4, pc + 32'd4);
    if (imem_req) check("addr_align", {30'd0, imem_addr[1:0]}, 32'd0);

    a = 1'b0;
    if (imem_req) begin
      case (mode)
        0: a = 1'b1;
        1: begin
          if (lat_cnt == 1) begin a = 1'b1; lat_cnt = 0; end
          else lat_cnt = lat_cnt + 1;
        end
        default: a = ($urandom_range(0, 2) != 0);
      endcase
    end else begin
      lat_cnt = 0;
    end

    stall       = st;
    redirect    = rd;
    redirect_pc = rpc;
    imem_ack    = a;
    imem_rdata  = a ? mem_word(imem_addr) : JUNK;

    if (instr_valid && !st && !rd) begin
      check("stream_pc", pc, exp_next);
      check("stream_instr", instr, mem_word(pc));
      exp_next = pc + 32'd4;
      n_consumed++;
    end
    if (rd) exp_next = {rpc[31:2], 2'b00};

    have_prev = 1'b1;
    p_hold    = instr_valid && st && !rd;
    p_req     = imem_req;
    p_ack     = a;
    p_stall   = st;
    p_rdr     = rd;
    p_valid   = instr_valid;
    p_pc      = pc;
    p_instr   = instr;
    p_addr    = imem_addr;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, imem_req, 1'b0);
    check({tag, "_valid"}, instr_valid, 1'b0);
    check({tag, "_instr"}, instr, NOP_WORD);
    check({tag, "_pc"}, pc, RESET_PC);
    check({tag, "_addr"}, imem_addr, RESET_PC);
    check({tag, "_pc4"}, pc_plus4, RESET_PC + 32'd4);
  endtask

  // Release reset with a stray ack on the bus; the idle cycle must ignore it.
  task automatic release_reset();
    imem_ack   = 1'b1;
    imem_rdata = JUNK;
    stall      = 1'b0;
    redirect   = 1'b0;
    @(negedge clk);
    rst       = 1'b0;
    exp_next  = RESET_PC;
    have_prev = 1'b0;
    lat_cnt   = 0;
  endtask

  initial begin
    rst = 1'b1; imem_ack = 1'b0; imem_rdata = '0;
    stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    have_prev = 1'b0; exp_next = RESET_PC;
    repeat (2) @(negedge clk);
    check_reset_outputs("reset");
    release_reset();

    // Ack every cycle: 0x100, 0x104, 0x108 with valid from the 3rd cycle.
    mode = 0;
    @(negedge clk);
    check("first_req", imem_req, 1'b1);
    check("first_addr", imem_addr, RESET_PC);
    check("first_valid", instr_valid, 1'b0);
    step(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("second_addr", imem_addr, RESET_PC + 32'd4);
    check("second_valid", instr_valid, 1'b1);
    check("second_pc", pc, RESET_PC);
    step(1'b0, 1'b0, 32'd0);
    @(negedge clk);
    check("third_addr", imem_addr, RESET_PC + 32'd8);
    step(1'b0, 1'b0, 32'd0);
    repeat (6) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end

    // Two-cycle memory latency.
    mode = 1;
    repeat (16) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end

    // Redirect to 0x203 on a cycle the request is outstanding without ack.
    found = 1'b0;
    for (int i = 0; i < 10 && !found; i++) begin
      @(negedge clk);
      if (imem_req && lat_cnt == 0) begin
        step(1'b0, 1'b1, 32'h0000_0203);
        found = 1'b1;
      end else begin
        step(1'b0, 1'b0, 32'd0);
      end
    end
    check("redirect_window", found, 1'b1);
    repeat (12) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end

    // Stall three cycles while acks keep arriving.
    mode = 0;
    repeat (4) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end
    repeat (3) begin @(negedge clk); step(1'b1, 1'b0, 32'd0); end
    repeat (6) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end

    // Address wrap through 0xFFFF_FFFC.
    @(negedge clk); step(1'b0, 1'b1, 32'hFFFF_FFF6);
    repeat (8) begin @(negedge clk); step(1'b0, 1'b0, 32'd0); end

    // Random traffic, with one reset dropped in while a request is open.
    mode = 2;
    did_reset = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      r_st = ($urandom_range(0, 9) < 3);
      r_rd = ($urandom_range(0, 19) == 0);
      r_pc = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15))) : $urandom;
      step(r_st, r_rd, r_pc);
      if (i >= 1500 && !did_reset && imem_req) begin
        did_reset = 1'b1;
        #2 rst = 1'b1;
        #1 check_reset_outputs("midreset");
        @(negedge clk);
        release_reset();
      end
    end
    check("midreset_done", did_reset, 1'b1);
    check("progress", (n_consumed > 800) ? 32'd1 : 32'd0, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
INSTR_FETCH -- requirements
Module: instr_fetch

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h0000_0000, meaning the first fetch address after reset.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock, all state on rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port imem_req, output, 1 bit: instruction memory request.
REQ-005 The block SHALL have port imem_addr, output, 32 bits: word-aligned request address.
REQ-006 The block SHALL have port imem_ack, input, 1 bit: memory returns imem_rdata for the pending request this cycle.
REQ-007 The block SHALL have port imem_rdata, input, 32 bits: instruction word, valid only when imem_ack=1.
REQ-008 The block SHALL have port stall, input, 1 bit: decode cannot accept; hold the IF/ID register.
REQ-009 The block SHALL have port redirect, input, 1 bit: branch/jump taken; one-cycle pulse.
REQ-010 The block SHALL have port redirect_pc, input, 32 bits: new fetch target, sampled when redirect=1.
REQ-011 The block SHALL have port instr_valid, output, 1 bit: instr/pc hold a valid instruction for decode and the immediate extender.
REQ-012 The block SHALL have port instr, output, 32 bits: IF/ID instruction register.
REQ-013 The block SHALL have port pc, output, 32 bits: address of instr.
REQ-014 The block SHALL have port pc_plus4, output, 32 bits: pc+4 modulo 2^32, combinational from pc.

Function
REQ-015 The FSM SHALL have states IDLE, FETCH, WAIT_DEC, FLUSH, registered, encoded in 2 bits.
REQ-016 IDLE SHALL drive imem_req=0 and move unconditionally to FETCH on the next cycle.
REQ-017 FETCH SHALL drive imem_req=1 with imem_addr=req_addr and hold both stable until imem_ack; one request outstanding max.
REQ-018 On imem_ack in FETCH with IF/ID free (instr_valid=0 or stall=0): instr<=imem_rdata, pc<=req_addr, instr_valid<=1, req_addr<=req_addr+4, stay FETCH (back-to-back requests allowed, zero bubble).
REQ-019 On imem_ack in FETCH with instr_valid=1 and stall=1: imem_rdata/req_addr SHALL go to a one-entry skid buffer, req_addr<=req_addr+4, next state WAIT_DEC.
REQ-020 WAIT_DEC SHALL drive imem_req=0; when stall=0, skid moves into IF/ID (instr_valid stays 1), next state FETCH.
REQ-021 FETCH cycles with no imem_ack and IF/ID consumed (stall=0) SHALL clear instr_valid next cycle; with stall=1, IF/ID SHALL hold.
REQ-022 redirect SHALL have priority over stall and ack: next cycle instr_valid=0, skid emptied, req_addr<=redirect_pc with bits[1:0] forced to 0.
REQ-023 redirect in FETCH without same-cycle imem_ack SHALL go to FLUSH; FLUSH keeps imem_req=1 and the old address until imem_ack, discards that data, then goes FETCH at the redirect target.
REQ-024 redirect with same-cycle imem_ack, or in IDLE/WAIT_DEC, SHALL go directly to FETCH at the redirect target; ack data discarded.
REQ-025 A second redirect while in FLUSH SHALL replace the pending target; the last target wins.
REQ-026 req_addr+4 SHALL wrap 32'hFFFF_FFFC -> 32'h0000_0000 without a flag.

Reset
REQ-027 On rst=1 (asynchronous): state=IDLE, req_addr=RESET_PC, imem_req=0, instr_valid=0, instr=32'h0000_0013 (NOP), pc=RESET_PC, skid empty.
REQ-028 Reset asserted mid-request SHALL abandon the request; a late imem_ack after reset release while in IDLE SHALL be ignored.

Structure
REQ-029 The shared package SHALL hold the FSM state encodings, the NOP constant 32'h0000_0013 and the instruction width 32.
REQ-030 The design SHALL be a single module; the skid buffer is inline and not a sub-module.

Verification
REQ-031 Reset, RESET_PC=0x100, ack every cycle -> imem_addr 0x100,0x104,0x108; instr_valid from the 3rd cycle after rst release; pc_plus4=pc+4.
REQ-032 Ack latency 2 cycles -> imem_req/imem_addr stable while waiting; instr_valid deasserts in gaps; no duplicate or skipped pc.
REQ-033 stall=1 for 3 cycles with ack arriving -> WAIT_DEC entered, imem_req=0, instr/pc held; after release, skid word follows with no loss.
REQ-034 redirect to 0x203 during a pending request -> FLUSH, old ack discarded, next imem_addr=0x200, instr_valid=0 until 0x200 returns.
REQ-035 req_addr=0xFFFF_FFFC with ack -> next imem_addr=0x0000_0000; rst asserted mid-request -> all outputs at reset values immediately.
